// File: rtl/fp32_pkg.sv
// Shared binary32 constants, FSM state encoding and operand classification
// used by the sequential floating-point datapath blocks.
package fp32_pkg;

  localparam int FP32_EXP_W   = 8;
  localparam int FP32_MAN_W   = 23;
  localparam int FP32_BIAS    = 127;
  localparam int FP32_EXP_MAX = 255;
  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

  localparam int FMUL_STEPS = FP32_MAN_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_NORM,
    ST_ROUND
  } fmul_state_t;

  typedef enum logic [1:0] {
    SPC_NONE,
    SPC_ZERO,
    SPC_INF,
    SPC_NAN
  } fp32_special_t;

  // Denormals carry a zero exponent field and therefore classify as zero.
  function automatic fp32_special_t fmul_classify(input logic [31:0] a, input logic [31:0] b);
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    a_zero = (a[30:23] == '0);
    b_zero = (b[30:23] == '0);
    a_inf  = (a[30:23] == '1) && (a[22:0] == '0);
    b_inf  = (b[30:23] == '1) && (b[22:0] == '0);
    a_nan  = (a[30:23] == '1) && (a[22:0] != '0);
    b_nan  = (b[30:23] == '1) && (b[22:0] != '0);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return SPC_NAN;
    if (a_inf || b_inf) return SPC_INF;
    if (a_zero || b_zero) return SPC_ZERO;
    return SPC_NONE;
  endfunction

endpackage

// File: rtl/fp32_round.sv
// Round-to-nearest-even of a normalised significand followed by the
// overflow-to-infinity / underflow-to-zero clamp on the final exponent.
module fp32_round
  import fp32_pkg::*;
(
  input  logic                  sign_i,
  input  logic [9:0]            exp_i,
  input  logic [FP32_MAN_W-1:0] man_i,
  input  logic                  guard_i,
  input  logic                  round_i,
  input  logic                  sticky_i,
  output logic [31:0]           result_o
);

  logic                inc;
  logic [FP32_MAN_W:0] man_sum;
  logic [9:0]          exp_adj;

  always_comb begin
    inc      = guard_i & (round_i | sticky_i | man_i[0]);
    man_sum  = {1'b0, man_i} + {{FP32_MAN_W{1'b0}}, inc};
    // A carry out of the mantissa leaves the field at zero and bumps the exponent.
    exp_adj  = exp_i + {9'b0, man_sum[FP32_MAN_W]};
    result_o = {sign_i, exp_adj[FP32_EXP_W-1:0], man_sum[FP32_MAN_W-1:0]};
    if ($signed(exp_adj) >= $signed(10'(FP32_EXP_MAX))) begin
      result_o = {sign_i, FP32_EXP_W'(FP32_EXP_MAX), {FP32_MAN_W{1'b0}}};
    end else if ($signed(exp_adj) <= $signed(10'sd0)) begin
      result_o = {sign_i, {(FP32_EXP_W + FP32_MAN_W){1'b0}}};
    end
  end

endmodule

// File: rtl/fmul_seq.sv
// Sequential binary32 multiplier: 24-step shift-add significand product,
// one normalise cycle and one round cycle, fixed 26-cycle latency.
module fmul_seq
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  fmul_state_t          state_q, state_d;
  logic [4:0]           cnt_q, cnt_d;
  logic [47:0]          acc_q, acc_d;
  logic [47:0]          mcand_q, mcand_d;
  logic [23:0]          mplier_q, mplier_d;
  logic                 sign_q, sign_d;
  logic [9:0]           exp_q, exp_d;
  logic [FP32_MAN_W-1:0] man_q, man_d;
  logic                 guard_q, guard_d;
  logic                 round_q, round_d;
  logic                 sticky_q, sticky_d;
  fp32_special_t        spc_q, spc_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [31:0]          result_q, result_d;
  logic [31:0]          rounded;

  fp32_round u_round (
    .sign_i   (sign_q),
    .exp_i    (exp_q),
    .man_i    (man_q),
    .guard_i  (guard_q),
    .round_i  (round_q),
    .sticky_i (sticky_q),
    .result_o (rounded)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    man_d    = man_q;
    guard_d  = guard_q;
    round_d  = round_q;
    sticky_d = sticky_q;
    spc_d    = spc_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    result_d = result_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_MUL;
          cnt_d    = '0;
          acc_d    = '0;
          mcand_d  = {24'b0, 1'b1, A[22:0]};
          mplier_d = {1'b1, B[22:0]};
          sign_d   = A[31] ^ B[31];
          exp_d    = {2'b00, A[30:23]} + {2'b00, B[30:23]} - 10'(FP32_BIAS);
          spc_d    = fmul_classify(A, B);
        end
      end
      ST_MUL: begin
        busy_d   = 1'b1;
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = {mcand_q[46:0], 1'b0};
        mplier_d = {1'b0, mplier_q[23:1]};
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == 5'(FMUL_STEPS - 1)) state_d = ST_NORM;
      end
      ST_NORM: begin
        busy_d  = 1'b1;
        state_d = ST_ROUND;
        // Product of two [1,2) significands lies in [1,4): bit 47 selects the shift.
        if (acc_q[47]) begin
          man_d    = acc_q[46:24];
          guard_d  = acc_q[23];
          round_d  = acc_q[22];
          sticky_d = |acc_q[21:0];
          exp_d    = exp_q + 10'd1;
        end else begin
          man_d    = acc_q[45:23];
          guard_d  = acc_q[22];
          round_d  = acc_q[21];
          sticky_d = |acc_q[20:0];
        end
      end
      ST_ROUND: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        unique case (spc_q)
          SPC_NAN:  result_d = FP32_QNAN;
          SPC_INF:  result_d = {sign_q, FP32_EXP_W'(FP32_EXP_MAX), {FP32_MAN_W{1'b0}}};
          SPC_ZERO: result_d = {sign_q, 31'b0};
          default:  result_d = rounded;
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      man_q    <= '0;
      guard_q  <= 1'b0;
      round_q  <= 1'b0;
      sticky_q <= 1'b0;
      spc_q    <= SPC_NONE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      man_q    <= man_d;
      guard_q  <= guard_d;
      round_q  <= round_d;
      sticky_q <= sticky_d;
      spc_q    <= spc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_fmul_seq.sv
// Self-checking bench for fmul_seq: directed rounding/special cases, start
// and reset robustness, and a random back-to-back run against a reference model.
module tb_fmul_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] A, B;
  logic        busy, done;
  logic [31:0] result;

  int vectors = 0;
  int miscompares = 0;

  fmul_seq dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Exact integer product of the significands, rounded to nearest even.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic            s;
    int              ea, eb, e, sh;
    logic            az, bz, ainf, binf, anan, bnan;
    longint unsigned ma, mb, p, keep, rem, half;
    s    = a[31] ^ b[31];
    ea   = int'(a[30:23]);
    eb   = int'(b[30:23]);
    az   = (ea == 0);
    bz   = (eb == 0);
    ainf = (ea == 255) && (a[22:0] == 0);
    binf = (eb == 255) && (b[22:0] == 0);
    anan = (ea == 255) && (a[22:0] != 0);
    bnan = (eb == 255) && (b[22:0] != 0);
    if (anan || bnan || (ainf && bz) || (binf && az)) return 32'h7FC0_0000;
    if (ainf || binf) return {s, 8'hFF, 23'h0};
    if (az || bz) return {s, 31'h0};
    ma = {40'h0, 1'b1, a[22:0]};
    mb = {40'h0, 1'b1, b[22:0]};
    p  = ma * mb;
    sh = (p >= (64'd1 << 47)) ? 24 : 23;
    e  = ea + eb - 127 + ((sh == 24) ? 1 : 0);
    keep = p >> sh;
    rem  = p - (keep << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && keep[0])) keep = keep + 1;
    if (keep == (64'd1 << 24)) begin
      keep = keep >> 1;
      e = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, 8'(e), keep[22:0]};
  endfunction

  function automatic logic [31:0] rand_normal();
    logic [7:0]  e;
    logic [22:0] m;
    logic        s;
    s = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 7) == 0) e = 8'($urandom_range(1, 254));
    else e = 8'($urandom_range(70, 184));
    m = 23'($urandom);
    return {s, e, m};
  endfunction

  // Issues one operation; lat is the slot (edges after acceptance) where done appears.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int busy_cycles);
    A = a;
    B = b;
    start = 1'b1;
    lat = -1;
    busy_cycles = 0;
    res = 32'h0;
    for (int k = 0; k <= 40; k++) begin
      tick();
      start = 1'b0;
      if (done) begin
        lat = k;
        res = result;
        break;
      end
      if (busy) busy_cycles++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    A = 32'h0;
    B = 32'h0;
    repeat (3) tick();
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
    vectors++;
    if (result !== 32'h0) begin miscompares++; $display("FAIL reset_result got %h want 00000000", result); end
    reset = 1'b0;
    tick();
    $display("reset: busy=%b done=%b result=%h", busy, done, result);
  endtask

  task automatic test_basic();
    logic [31:0] res;
    int lat, bc;
    run_op(32'h3FC0_0000, 32'h4000_0000, res, lat, bc);
    $display("basic: A=3fc00000 B=40000000 result=%h latency=%0d busy=%0d", res, lat, bc);
    vectors++;
    if (res !== 32'h4040_0000) begin miscompares++; $display("FAIL basic_result got %h want 40400000", res); end
    vectors++;
    if (lat != 26) begin miscompares++; $display("FAIL basic_latency got %0d want 26", lat); end
    vectors++;
    if (bc != 25) begin miscompares++; $display("FAIL basic_busy_cycles got %0d want 25", bc); end
    tick();
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL basic_done_pulse got %b want 0", done); end
    vectors++;
    if (result !== 32'h4040_0000) begin miscompares++; $display("FAIL basic_result_hold got %h want 40400000", result); end
  endtask

  task automatic run_table(input string name, input logic [31:0] ta[], input logic [31:0] tb_[],
                           input logic [31:0] te[]);
    logic [31:0] res;
    int lat, bc;
    foreach (ta[i]) begin
      run_op(ta[i], tb_[i], res, lat, bc);
      $display("%s: A=%h B=%h result=%h latency=%0d", name, ta[i], tb_[i], res, lat);
      vectors++;
      if (res !== te[i]) begin
        miscompares++;
        $display("FAIL %s_result[%0d] got %h want %h", name, i, res, te[i]);
      end
      vectors++;
      if (lat != 26) begin
        miscompares++;
        $display("FAIL %s_latency[%0d] got %0d want 26", name, i, lat);
      end
    end
  endtask

  task automatic test_rounding();
    logic [31:0] ta[] = '{32'h4040_0000, 32'h3F80_0800, 32'h3F80_0001, 32'h3FFF_FFFF};
    logic [31:0] tb_[] = '{32'hBF00_0000, 32'h3F80_0800, 32'h3F80_0001, 32'h3FFF_FFFF};
    logic [31:0] te[] = '{32'hBFC0_0000, 32'h3F80_1000, 32'h3F80_0002, 32'h407F_FFFE};
    run_table("round", ta, tb_, te);
  endtask

  task automatic test_special();
    logic [31:0] ta[] = '{32'h7F00_0000, 32'h7F80_0000, 32'h0040_0000, 32'hFFC1_2345,
                          32'hFF80_0000, 32'h8000_0000, 32'h8080_0000};
    logic [31:0] tb_[] = '{32'h7F00_0000, 32'h0000_0000, 32'h3F80_0000, 32'h4000_0000,
                           32'h4000_0000, 32'h4040_0000, 32'h0080_0000};
    logic [31:0] te[] = '{32'h7F80_0000, 32'h7FC0_0000, 32'h0000_0000, 32'h7FC0_0000,
                          32'hFF80_0000, 32'h8000_0000, 32'h8000_0000};
    run_table("special", ta, tb_, te);
  endtask

  task automatic test_start_ignored();
    int dones = 0;
    int done_slot = -1;
    logic [31:0] res = 32'h0;
    A = 32'h4040_0000;
    B = 32'hBF00_0000;
    start = 1'b1;
    for (int k = 0; k <= 40; k++) begin
      tick();
      start = 1'b0;
      if (k == 4 || k == 24) begin
        A = 32'h3FC0_0000;
        B = 32'h4000_0000;
        start = 1'b1;
      end
      if (done) begin
        dones++;
        done_slot = k;
        res = result;
      end
    end
    start = 1'b0;
    $display("restart: result=%h dones=%0d done_slot=%0d", res, dones, done_slot);
    vectors++;
    if (dones != 1) begin miscompares++; $display("FAIL restart_done_count got %0d want 1", dones); end
    vectors++;
    if (res !== 32'hBFC0_0000) begin miscompares++; $display("FAIL restart_result got %h want bfc00000", res); end
    vectors++;
    if (done_slot != 26) begin miscompares++; $display("FAIL restart_latency got %0d want 26", done_slot); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] res;
    int lat, bc;
    int dones = 0;
    A = 32'h4000_0000;
    B = 32'h4000_0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    $display("abort: busy=%b done=%b result=%h", busy, done, result);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy got %b want 0", busy); end
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL abort_done got %b want 0", done); end
    vectors++;
    if (result !== 32'h0) begin miscompares++; $display("FAIL abort_result got %h want 00000000", result); end
    repeat (40) begin
      tick();
      if (done) dones++;
    end
    vectors++;
    if (dones != 0) begin miscompares++; $display("FAIL abort_stray_done got %0d want 0", dones); end
    run_op(32'h4000_0000, 32'h4000_0000, res, lat, bc);
    $display("abort_fresh: A=40000000 B=40000000 result=%h latency=%0d", res, lat);
    vectors++;
    if (res !== 32'h4080_0000) begin miscompares++; $display("FAIL abort_fresh_result got %h want 40800000", res); end
    vectors++;
    if (lat != 26) begin miscompares++; $display("FAIL abort_fresh_latency got %0d want 26", lat); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    logic [31:0] a_q[$];
    logic [31:0] b_q[$];
    int issued = 0;
    int checked = 0;
    int since = 0;
    int cyc = -1;
    int last_done = 0;
    A = rand_normal();
    B = rand_normal();
    start = 1'b1;
    a_q.push_back(A);
    b_q.push_back(B);
    exp_q.push_back(ref_mul(A, B));
    issued = 1;
    while (checked < 100 && since < 40) begin
      tick();
      start = 1'b0;
      cyc++;
      since++;
      if (done) begin
        $display("b2b[%0d]: A=%h B=%h result=%h expect=%h gap=%0d",
                 checked, a_q[0], b_q[0], result, exp_q[0], cyc - last_done);
        vectors++;
        if (result !== exp_q[0]) begin
          miscompares++;
          $display("FAIL b2b_result[%0d] got %h want %h", checked, result, exp_q[0]);
        end
        vectors++;
        if ((cyc - last_done) != ((checked == 0) ? 26 : 27)) begin
          miscompares++;
          $display("FAIL b2b_spacing[%0d] got %0d want %0d", checked, cyc - last_done,
                   (checked == 0) ? 26 : 27);
        end
        last_done = cyc;
        void'(exp_q.pop_front());
        void'(a_q.pop_front());
        void'(b_q.pop_front());
        checked++;
        since = 0;
        if (issued < 100) begin
          A = rand_normal();
          B = rand_normal();
          start = 1'b1;
          a_q.push_back(A);
          b_q.push_back(B);
          exp_q.push_back(ref_mul(A, B));
          issued++;
        end
      end
    end
    start = 1'b0;
    if (checked < 100) begin
      vectors++;
      miscompares++;
      $display("FAIL b2b_timeout got %0d results want 100", checked);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    A = 32'h0;
    B = 32'h0;
    test_reset();
    test_basic();
    test_rounding();
    test_special();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fmul_seq.md
FMUL_SEQ -- requirements
Module: fmul_seq

Interface
REQ-001 SHALL have no parameters; the format is fixed at IEEE-754 binary32.
REQ-002 SHALL have port `clk`, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port `start`, input, 1 bit: request to multiply; sampled only in IDLE.
REQ-005 SHALL have port `A`, input, 32 bits: multiplicand, sampled together with `start`.
REQ-006 SHALL have port `B`, input, 32 bits: multiplier, sampled together with `start`.
REQ-007 SHALL have port `busy`, output, 1 bit: high from the cycle after `start` is accepted until `done` rises.
REQ-008 SHALL have port `done`, output, 1 bit: single-cycle pulse marking that `result` is valid.
REQ-009 SHALL have port `result`, output, 32 bits: the product A*B, registered and held until the next accepted `start`.

Function
REQ-010 SHALL use four states:
- IDLE: waits for `start`; on `start`=1, latches A and B, then goes to MUL.
- MUL: 24 cycles, one shift-add step of the 24x24 significand product per cycle.
- NORM: 1 cycle; normalises the 48-bit product and adjusts the exponent.
- ROUND: 1 cycle; rounds, writes `result`, pulses `done`, returns to IDLE.
REQ-011 SHALL have a fixed latency: `done` is high exactly 26 cycles after the cycle in which `start` was sampled high in IDLE.
REQ-012 SHALL ignore `start` while `busy`=1 or during the `done` cycle; such a request is neither queued nor allowed to corrupt the operation in flight.
REQ-013 SHALL compute the exponent as eA+eB-127 in a 10-bit signed intermediate, plus 1 if product bit 47 is set.
REQ-014 SHALL set sign = A[31] XOR B[31] for every output, including zero and infinity.
REQ-015 SHALL round to nearest, ties to even, using guard, round and sticky bits (sticky = OR of all discarded product bits); a mantissa carry-out SHALL increment the exponent.
REQ-016 SHALL flush denormal inputs to signed zero and produce no denormal outputs.
REQ-017 SHALL return signed infinity (exponent 255, mantissa 0) when the final exponent is 255 or more.
REQ-018 SHALL return signed zero when the final exponent is 0 or less (underflow).
REQ-019 SHALL return 0x7FC00000 if either operand is NaN, or for infinity times zero.
REQ-020 SHALL return signed infinity for infinity times a finite nonzero value, and signed zero for zero times a finite value.
REQ-021 SHALL still take the full 26-cycle latency for all special cases of REQ-016 to REQ-020.
REQ-022 SHALL, when `start` is accepted in the cycle immediately after `done`, begin a new operation normally (back-to-back issue every 27 cycles).

Reset
REQ-023 SHALL, with `reset`=1 at a clock edge, force state to IDLE and clear `busy`, `done`, `result` (to 0x00000000), the operand registers, the accumulator and the cycle counter.
REQ-024 SHALL abort any operation in flight on reset, with no `done` pulse for it.
REQ-025 SHALL give `reset` priority over `start` in the same cycle.

Structure
REQ-026 SHALL take from a shared package `fp32_pkg` the constants FP32_BIAS (127), FP32_QNAN (0x7FC00000), FP32_EXP_MAX (255) and the mantissa/exponent field widths.
REQ-027 SHALL place the round-to-nearest-even logic and the overflow/underflow clamp in one combinational sub-module, `fp32_round`, reusable by the adder and multiplier blocks.
REQ-028 SHALL be built from the FSM, the 5-bit cycle counter, the 48-bit accumulator and the special-case flags captured at IDLE, inside fmul_seq.

Verification
REQ-029 SHALL check: A=0x3FC00000, B=0x40000000, `start` 1 cycle -> `done` 26 cycles later, `result`=0x40400000, `busy` high for 25 cycles.
REQ-030 SHALL check: A=0x40400000, B=0xBF000000 -> 0xBFC00000; then A=0x3F800800, B=0x3F800800 -> 0x3F801000 (round-to-even tie); then A=0x3F800001, B=0x3F800001 -> 0x3F800002.
REQ-031 SHALL check: A=0x7F000000, B=0x7F000000 -> 0x7F800000; A=0x7F800000, B=0x00000000 -> 0x7FC00000; A=0x00400000 (denormal), B=0x3F800000 -> 0x00000000; every case still takes 26 cycles.
REQ-032 SHALL check: `start` re-pulsed with different operands at cycles 5 and 25 of an operation -> `result` reflects only the first operands and exactly one `done` pulse occurs.
REQ-033 SHALL check: `reset` asserted at cycle 10 of an operation -> the next cycle shows `busy`=0, `done`=0, `result`=0, and no `done` follows; a fresh `start` then completes normally.
REQ-034 SHALL check: back-to-back `start` in the cycle after `done`, 100 random normal operand pairs -> results bit-exact against a reference model.
